// File: rtl/sd_access_arbiter.sv
// Round-robin arbiter sharing one SPI-mode SD controller between two requesters, one 32-byte sector per grant.
// Issues a one-cycle rd/wr strobe, routes the byte stream to the granted port, and aborts hung transfers via sd_reset.
module sd_access_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd2_000_000,
  parameter logic [31:0] SD_RESET_CYCLES = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [63:0] req_addr,
  input  logic [15:0] wdata,
  output logic [1:0]  wnext,
  output logic [7:0]  rdata,
  output logic [1:0]  rvalid,
  output logic [1:0]  done,
  output logic        err,
  output logic        grant,
  output logic        busy,
  output logic [6:0]  xfer_count,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_address,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  input  logic        sd_ready_for_next_byte,
  input  logic        sd_ready,
  output logic        sd_reset
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RECOVER, DONE} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [6:0]  xfer_count_q, xfer_count_d;
  logic [31:0] wdog_q, wdog_d;
  logic [31:0] rst_cnt_q, rst_cnt_d;
  logic        ba_q, ba_d;
  logic        rn_q, rn_d;

  logic in_xfer;
  logic strobe_edge;
  logic pick;

  assign in_xfer     = (state_q == WAIT_START) || (state_q == WAIT_DONE);
  assign strobe_edge = we_q ? (sd_ready_for_next_byte && !rn_q) : (sd_byte_available && !ba_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    addr_d       = addr_q;
    xfer_count_d = xfer_count_q;
    wdog_d       = wdog_q;
    rst_cnt_d    = rst_cnt_q;
    ba_d         = sd_byte_available;
    rn_d         = sd_ready_for_next_byte;
    pick         = 1'b0;

    case (state_q)
      IDLE: begin
        if (sd_ready && (req != 2'b00)) begin
          pick    = (req == 2'b11) ? ~last_grant_q : req[1];
          grant_d = pick;
          we_d    = we[pick];
          addr_d  = pick ? req_addr[63:32] : req_addr[31:0];
          if (addr_d[4:0] != 5'd0) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        xfer_count_d = 7'd0;
        // The issue cycle itself counts toward the timeout.
        wdog_d       = 32'd1;
        state_d      = WAIT_START;
      end
      WAIT_START, WAIT_DONE: begin
        wdog_d = wdog_q + 32'd1;
        if (strobe_edge && (xfer_count_q != 7'd127)) begin
          xfer_count_d = xfer_count_q + 7'd1;
        end
        if ((state_q == WAIT_START) && !sd_ready) begin
          state_d = WAIT_DONE;
        end else if ((state_q == WAIT_DONE) && sd_ready) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wdog_d >= TIMEOUT_CYCLES) begin
          rst_cnt_d = 32'd0;
          state_d   = RECOVER;
        end
      end
      RECOVER: begin
        rst_cnt_d = rst_cnt_q + 32'd1;
        if (rst_cnt_q >= SD_RESET_CYCLES - 32'd1) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!req[grant_q]) begin
          last_grant_d = grant_q;
          err_d        = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= 32'd0;
      xfer_count_q <= 7'd0;
      wdog_q       <= 32'd0;
      rst_cnt_q    <= 32'd0;
      ba_q         <= 1'b0;
      rn_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      xfer_count_q <= xfer_count_d;
      wdog_q       <= wdog_d;
      rst_cnt_q    <= rst_cnt_d;
      ba_q         <= ba_d;
      rn_q         <= rn_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign sd_rd      = (state_q == ISSUE) && !we_q;
  assign sd_wr      = (state_q == ISSUE) && we_q;
  assign sd_reset   = (state_q == RECOVER);
  assign done       = (state_q == DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign err        = (state_q == DONE) && err_q;
  assign grant      = grant_q;
  assign sd_address = addr_q;
  assign xfer_count = xfer_count_q;
  assign rdata      = sd_dout;
  assign sd_din     = grant_q ? wdata[15:8] : wdata[7:0];
  assign rvalid     = in_xfer ? {grant_q && sd_byte_available, !grant_q && sd_byte_available} : 2'b00;
  assign wnext      = in_xfer ? {grant_q && sd_ready_for_next_byte, !grant_q && sd_ready_for_next_byte} : 2'b00;

endmodule

// File: doc/sd_access_arbiter.md
# sd_access_arbiter

Shares the single SPI-mode SD card controller between two requesters, for example a CPU bus bridge and a boot/asset loader. It grants one 32-byte sector transfer at a time, round-robin. It sequences the controller's one-cycle `rd`/`wr` start and routes the byte stream to the granted port. It also rejects misaligned addresses and recovers a hung transfer with a watchdog that resets the controller.

## Interface
- `TIMEOUT_CYCLES`, 32'd2_000_000: maximum cycles from `sd_rd`/`sd_wr` issue to transfer end before abort.
- `SD_RESET_CYCLES`, 4: width of the `sd_reset` pulse on abort.
- `clk`  in  1  system clock (25 MHz), shared with the SD controller.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  2  per-port transfer request (bit n = port n), level, 4-phase.
- `we`  in  2  per-port direction: 1 = write, 0 = read; sampled at grant.
- `req_addr`  in  64  {port1, port0} byte addresses; must be a multiple of 32; sampled at grant.
- `wdata`  in  16  {port1, port0} write byte presented to the SD controller.
- `wnext`  out  2  forwarded write-byte request, granted port only.
- `rdata`  out  8  read byte (shared by both ports).
- `rvalid`  out  2  forwarded byte-available, granted port only.
- `done`  out  2  transfer finished; held until that port drops `req`.
- `err`  out  1  qualifies `done`: misaligned address or timeout.
- `grant`  out  1  index of the current or last granted port.
- `busy`  out  1  high in every state except IDLE.
- `xfer_count`  out  7  bytes strobed in the current/last transfer.
- `sd_rd`, `sd_wr`  out  1 each  start strobes to the controller.
- `sd_address`  out  32  registered address to the controller.
- `sd_din`  out  8  equals `wdata` of the granted port (combinational).
- `sd_dout`  in  8; `sd_byte_available`, `sd_ready_for_next_byte`, `sd_ready`  in  1 each: controller outputs.
- `sd_reset`  out  1  controller reset.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, RECOVER, DONE.
- **IDLE**: if `sd_ready`=1 and `req`≠0, pick a port.
  - Single requester wins.
  - If both request, the port ≠ `last_grant` wins.
  - Latch `grant`, `we`, and the address into `sd_address`.
  - If address[4:0]≠0: set `err`=1 and go to DONE; SD strobes are never asserted.
  - Otherwise go to ISSUE.
- **ISSUE**: exactly one cycle of `sd_rd` (we=0) or `sd_wr` (we=1). Clear `xfer_count` and the watchdog. Go to WAIT_START.
- **WAIT_START**: wait for `sd_ready`=0, then go to WAIT_DONE.
- **WAIT_DONE**: wait for `sd_ready`=1, then go to DONE with `err`=0.
- **Watchdog**: counts in WAIT_START and WAIT_DONE. When it reaches `TIMEOUT_CYCLES`, go to RECOVER.
- **RECOVER**: `sd_reset`=1 for `SD_RESET_CYCLES` cycles, then DONE with `err`=1.
- **DONE**: `done[grant]`=1. When `req[grant]`=0, set `last_grant`←`grant` and go to IDLE. `err` holds until exit.
- **Routing** (WAIT_START, WAIT_DONE only; outputs are 0 otherwise):
  - `rvalid[grant]`=`sd_byte_available`.
  - `wnext[grant]`=`sd_ready_for_next_byte`.
  - `rdata`=`sd_dout` always.
  - The non-granted port always sees 0.
- **xfer_count**: +1 on each rising edge (registered previous value) of `sd_byte_available` for reads, or of `sd_ready_for_next_byte` for writes. Saturates at 127. Holds until the next ISSUE.

## Timing
- Reset values:
  - State IDLE; `last_grant`=1, so port 0 wins the first collision.
  - `grant`=0, `sd_address`=0, `xfer_count`=0.
  - All strobes, `done`, `err`, `busy`, `sd_reset` = 0.
- Reset is asynchronous. Assertion mid-transfer forces IDLE and zeros outputs immediately. No `sd_reset` is issued; the controller has its own reset.
- Latency from `req` to SD strobe: IDLE sample (1) + ISSUE (1). The strobe is high in cycle 2 after `req` if `sd_ready`=1.
- Misaligned address: `done`+`err` from cycle 2.
- `done` rises 1 cycle after `sd_ready` returns high.
- Forwarding of `rvalid`, `wnext` and `sd_din` has zero latency (combinational).
- A new `req` from the same port is not considered until DONE exits. A port cannot win twice in a row while the other is requesting.
- `req` dropped before `done`: the transfer still completes, and DONE exits on its first cycle.
- If `sd_ready`=0 in IDLE, requests wait indefinitely; no watchdog runs.

## Test plan
- **Port 0 read at 0x40**: BFM ready, pulses `byte_available` 4× with 0xA1..0xA4. Required response:
  - `sd_rd` high exactly 1 cycle; `sd_address`=0x40.
  - `rvalid[0]` mirrors the pulses with `rdata` matching; `rvalid[1]`=0.
  - `done[0]` held until `req[0]` drops; `xfer_count`=4; `err`=0.
- **Port 1 write at 0x80, `wdata[15:8]` stepping 0x10..0x2F**: `sd_wr` 1 cycle; `sd_din` follows port 1; `wnext[1]` mirrors the controller; `done[1]`; `xfer_count`=32.
- **Both ports request right after reset**: port 0 served first, then port 1. Next simultaneous request serves port 0, then port 1 again.
- **Port 0 read at 0x23**: `done[0]`=1, `err`=1 in cycle 2; `sd_rd`/`sd_wr` never asserted; `sd_reset`=0.
- **Timeout with `TIMEOUT_CYCLES`=100, BFM never drops `sd_ready` after `sd_rd`**: `sd_reset` high 4 cycles starting 100 cycles after ISSUE, then `done[0]`+`err`. The next request proceeds normally.
- **Async `reset` in WAIT_DONE**: outputs zero in the same cycle, `busy`=0. After release, a port 1 request wins over a simultaneous port 0 request? No: port 0 wins (`last_grant`=1).
